vic_irq_arbiter: RTL and testbench

Interrupt source arbiter sitting directly upstream of the vector interrupt controller stage. Captures rising edges on up to 32 peripheral interrupt lines into a pending register, applies a software mask, selects the highest-priority pending source and issues a one-cycle IRQ strobe plus a 5-bit ISR index to the controller. It then holds that request in service until the core signals return-from-interrupt.

---
 rtl/vic_irq_arbiter.sv | 171 +++++++++++++++++
 tb/tb_vic_irq_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vic_irq_arbiter.sv
// vic_irq_arbiter: edge-captured interrupt arbiter feeding the vector interrupt
// controller. Rising edges on i_irq_src set pending bits, the lowest-index
// unmasked pending source is granted with a one-cycle o_IRQ strobe, and the
// grant is held in service until i_reti.
// Optional feature: define VIC_NESTING_EN to allow a lower-index source to
// preempt the one in service, with up to STACK_DEPTH interrupted indices saved.
module vic_irq_arbiter #(
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] i_irq_src,
  input  logic             i_mask_we,
  input  logic [N_SRC-1:0] i_mask_wdata,
  input  logic             i_reti,
  input  logic             i_lost_clr,
  output logic             o_IRQ,
  output logic [4:0]       o_ISR_addr,
  output logic             o_busy,
  output logic [N_SRC-1:0] o_pending,
  output logic [N_SRC-1:0] o_mask,
  output logic             o_lost
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t           r_state;
  logic [N_SRC-1:0] r_src_q;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_mask;
  logic             r_lost;
  logic             r_irq;
  logic             r_busy;
  logic [4:0]       r_isr_addr;

  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_grant_vec;
  logic [N_SRC-1:0] w_loss;
  logic             w_any;
  logic [4:0]       w_win;
  logic             w_grant;
  logic             w_preempt;

  assign w_edge = i_irq_src & ~r_src_q;
  assign w_elig = r_pending & ~r_mask;

  // Lowest-index eligible source wins
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_any = 1'b1;
        w_win = 5'(i);
      end
    end
  end

`ifdef VIC_NESTING_EN
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [4:0]      r_stack [STACK_DEPTH];
  logic [SP_W-1:0] r_sp;
  logic            w_full;
  logic            w_empty;

  assign w_full  = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty = (r_sp == '0);
  // A return in the same cycle takes precedence over preemption
  assign w_preempt = (r_state == ST_SERVICE) && !i_reti && w_any &&
                     (w_win < r_isr_addr) && !w_full;

  // Save the interrupted index on preemption, restore it on return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp <= '0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) r_stack[i] <= '0;
    end else if (w_preempt) begin
      r_stack[IDX_W'(r_sp)] <= r_isr_addr;
      r_sp                  <= r_sp + SP_W'(1);
    end else if ((r_state == ST_SERVICE) && i_reti && !w_empty) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end
`else
  assign w_preempt = 1'b0;
`endif

  assign w_grant     = ((r_state == ST_IDLE) && w_any) || w_preempt;
  assign w_grant_vec = w_grant ? (N_SRC'(1) << w_win) : '0;
  assign w_loss      = w_edge & r_pending & ~w_grant_vec;

  // Edge capture, pending bookkeeping, mask register and sticky loss flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_q   <= '0;
      r_pending <= '0;
      r_mask    <= '1;
      r_lost    <= 1'b0;
    end else begin
      r_src_q   <= i_irq_src;
      r_pending <= (r_pending & ~w_grant_vec) | w_edge;
      if (i_mask_we) r_mask <= i_mask_wdata;
      if (|w_loss)         r_lost <= 1'b1;
      else if (i_lost_clr) r_lost <= 1'b0;
    end
  end

  // Request/service state machine with registered strobe, busy and index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_irq      <= 1'b0;
      r_busy     <= 1'b0;
      r_isr_addr <= '0;
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state    <= ST_REQ;
            r_irq      <= 1'b1;
            r_busy     <= 1'b1;
            r_isr_addr <= w_win;
          end
        end
        ST_REQ: begin
          r_state <= ST_SERVICE;
        end
        ST_SERVICE: begin
          if (i_reti) begin
`ifdef VIC_NESTING_EN
            if (!w_empty) begin
              r_isr_addr <= r_stack[IDX_W'(r_sp - SP_W'(1))];
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
`else
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
`endif
          end else if (w_preempt) begin
            r_state    <= ST_REQ;
            r_irq      <= 1'b1;
            r_isr_addr <= w_win;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_IRQ      = r_irq;
  assign o_ISR_addr = r_isr_addr;
  assign o_busy     = r_busy;
  assign o_pending  = r_pending;
  assign o_mask     = r_mask;
  assign o_lost     = r_lost;

endmodule

// File: tb/tb_vic_irq_arbiter.sv
// Testbench for vic_irq_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_vic_irq_arbiter;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned VW    = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] i_irq_src = '0;
  logic         i_mask_we = 1'b0;
  logic [N-1:0] i_mask_wdata = '0;
  logic         i_reti = 1'b0;
  logic         i_lost_clr = 1'b0;
  logic         o_IRQ;
  logic [4:0]   o_ISR_addr;
  logic         o_busy;
  logic [N-1:0] o_pending;
  logic [N-1:0] o_mask;
  logic         o_lost;

  int n_tests = 0;
  int n_fail  = 0;

  vic_irq_arbiter #(.N_SRC(N), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_irq_src(i_irq_src), .i_mask_we(i_mask_we),
    .i_mask_wdata(i_mask_wdata), .i_reti(i_reti), .i_lost_clr(i_lost_clr),
    .o_IRQ(o_IRQ), .o_ISR_addr(o_ISR_addr), .o_busy(o_busy),
    .o_pending(o_pending), .o_mask(o_mask), .o_lost(o_lost)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {irq, busy, addr, pending, mask, lost}
  logic [VW-1:0] obs;
  assign obs = {o_IRQ, o_busy, o_ISR_addr, o_pending, o_mask, o_lost};

  // Reference model: service mode 0=idle 1=strobe 2=in service, queue as stack
  int           m_mode;
  bit [N-1:0]   m_pend, m_mask, m_prev;
  bit           m_lost, m_irq;
  int           m_addr;
  int           m_stack[$];
  logic [VW-1:0] mdl;
  assign mdl = {m_irq, (m_mode != 0), 5'(m_addr), m_pend, m_mask, m_lost};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_pend = '0; m_mask = '1; m_prev = '0;
      m_lost = 1'b0; m_irq = 1'b0; m_addr = 0; m_stack.delete();
    end else begin
      bit [N-1:0] edges, elig, gmask;
      int win, grant;
      edges = i_irq_src & ~m_prev;
      elig  = m_pend & ~m_mask;
      win = -1;
      for (int i = N - 1; i >= 0; i--) if (elig[i]) win = i;
      grant = -1;
      m_irq = 1'b0;
      if (m_mode == 0) begin
        if (win >= 0) grant = win;
      end else if (m_mode == 1) begin
        m_mode = 2;
      end else if (i_reti) begin
        if (m_stack.size() > 0) m_addr = m_stack.pop_back();
        else m_mode = 0;
      end
`ifdef VIC_NESTING_EN
      else if (win >= 0 && win < m_addr && m_stack.size() < DEPTH) begin
        m_stack.push_back(m_addr);
        grant = win;
      end
`endif
      gmask = '0;
      if (grant >= 0) begin
        gmask[grant] = 1'b1;
        m_addr = grant; m_mode = 1; m_irq = 1'b1;
      end
      if ((edges & m_pend & ~gmask) != 0) m_lost = 1'b1;
      else if (i_lost_clr) m_lost = 1'b0;
      m_pend = (m_pend & ~gmask) | edges;
      if (i_mask_we) m_mask = i_mask_wdata;
      m_prev = i_irq_src;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_tests++;
    if (obs !== {1'b0, 1'b0, 5'd0, 8'h00, 8'hFF, 1'b0}) begin
      n_fail++; $display("FAIL reset_held got=%h exp=%h", obs, {1'b0, 1'b0, 5'd0, 8'h00, 8'hFF, 1'b0});
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (obs !== {1'b0, 1'b0, 5'd0, 8'h00, 8'hFF, 1'b0}) begin
      n_fail++; $display("FAIL reset_release got=%h exp=%h", obs, {1'b0, 1'b0, 5'd0, 8'h00, 8'hFF, 1'b0});
    end
  endtask

  task automatic test_basic();
    i_mask_we = 1'b1; i_mask_wdata = 8'h00; tick(); i_mask_we = 1'b0;
    i_irq_src = 8'h08; tick();
    n_tests++;
    if (obs !== {1'b0, 1'b0, 5'd0, 8'h08, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL basic_pending got=%h exp=%h", obs, {1'b0, 1'b0, 5'd0, 8'h08, 8'h00, 1'b0});
    end
    i_irq_src = 8'h00; tick();
    n_tests++;
    if (obs !== {1'b1, 1'b1, 5'd3, 8'h00, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL basic_strobe got=%h exp=%h", obs, {1'b1, 1'b1, 5'd3, 8'h00, 8'h00, 1'b0});
    end
    tick();
    n_tests++;
    if (obs !== {1'b0, 1'b1, 5'd3, 8'h00, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL basic_service got=%h exp=%h", obs, {1'b0, 1'b1, 5'd3, 8'h00, 8'h00, 1'b0});
    end
    i_reti = 1'b1; tick(); i_reti = 1'b0;
    n_tests++;
    if (obs !== {1'b0, 1'b0, 5'd3, 8'h00, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL basic_reti got=%h exp=%h", obs, {1'b0, 1'b0, 5'd3, 8'h00, 8'h00, 1'b0});
    end
  endtask

  task automatic test_mask_unmask();
    i_mask_we = 1'b1; i_mask_wdata = 8'hFF; tick(); i_mask_we = 1'b0;
    i_irq_src = 8'h04; tick(); i_irq_src = 8'h00; tick(); tick();
    n_tests++;
    if (obs !== {1'b0, 1'b0, 5'd3, 8'h04, 8'hFF, 1'b0}) begin
      n_fail++; $display("FAIL masked_hold got=%h exp=%h", obs, {1'b0, 1'b0, 5'd3, 8'h04, 8'hFF, 1'b0});
    end
    i_mask_we = 1'b1; i_mask_wdata = 8'hFB; tick(); i_mask_we = 1'b0;
    n_tests++;
    if (obs !== {1'b0, 1'b0, 5'd3, 8'h04, 8'hFB, 1'b0}) begin
      n_fail++; $display("FAIL unmask_write got=%h exp=%h", obs, {1'b0, 1'b0, 5'd3, 8'h04, 8'hFB, 1'b0});
    end
    tick();
    n_tests++;
    if (obs !== {1'b1, 1'b1, 5'd2, 8'h00, 8'hFB, 1'b0}) begin
      n_fail++; $display("FAIL unmask_strobe got=%h exp=%h", obs, {1'b1, 1'b1, 5'd2, 8'h00, 8'hFB, 1'b0});
    end
    tick(); i_reti = 1'b1; tick(); i_reti = 1'b0;
    n_tests++;
    if (obs !== {1'b0, 1'b0, 5'd2, 8'h00, 8'hFB, 1'b0}) begin
      n_fail++; $display("FAIL unmask_reti got=%h exp=%h", obs, {1'b0, 1'b0, 5'd2, 8'h00, 8'hFB, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    i_mask_we = 1'b1; i_mask_wdata = 8'h00; tick(); i_mask_we = 1'b0;
    i_irq_src = 8'h22; tick(); i_irq_src = 8'h00;
    tick();
    n_tests++;
    if (obs !== {1'b1, 1'b1, 5'd1, 8'h20, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL b2b_first got=%h exp=%h", obs, {1'b1, 1'b1, 5'd1, 8'h20, 8'h00, 1'b0});
    end
    tick(); i_reti = 1'b1; tick(); i_reti = 1'b0;
    n_tests++;
    if (obs !== {1'b0, 1'b0, 5'd1, 8'h20, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL b2b_idle got=%h exp=%h", obs, {1'b0, 1'b0, 5'd1, 8'h20, 8'h00, 1'b0});
    end
    tick();
    n_tests++;
    if (obs !== {1'b1, 1'b1, 5'd5, 8'h00, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL b2b_second got=%h exp=%h", obs, {1'b1, 1'b1, 5'd5, 8'h00, 8'h00, 1'b0});
    end
    tick(); i_reti = 1'b1; tick(); i_reti = 1'b0;
  endtask

  task automatic test_lost();
    i_mask_we = 1'b1; i_mask_wdata = 8'hFF; tick(); i_mask_we = 1'b0;
    i_irq_src = 8'h10; tick(); i_irq_src = 8'h00; tick();
    i_irq_src = 8'h10; tick(); i_irq_src = 8'h00;
    n_tests++;
    if (obs !== {1'b0, 1'b0, 5'd5, 8'h10, 8'hFF, 1'b1}) begin
      n_fail++; $display("FAIL lost_set got=%h exp=%h", obs, {1'b0, 1'b0, 5'd5, 8'h10, 8'hFF, 1'b1});
    end
    i_lost_clr = 1'b1; tick(); i_lost_clr = 1'b0;
    n_tests++;
    if (o_lost !== 1'b0) begin
      n_fail++; $display("FAIL lost_clear got=%b exp=0", o_lost);
    end
    i_irq_src = 8'h10; i_lost_clr = 1'b1; tick(); i_irq_src = 8'h00; i_lost_clr = 1'b0;
    n_tests++;
    if (o_lost !== 1'b1) begin
      n_fail++; $display("FAIL lost_clr_vs_loss got=%b exp=1", o_lost);
    end
    i_lost_clr = 1'b1; tick(); i_lost_clr = 1'b0;
    i_mask_we = 1'b1; i_mask_wdata = 8'h00; tick(); i_mask_we = 1'b0;
    tick();
    n_tests++;
    if (obs !== {1'b1, 1'b1, 5'd4, 8'h00, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL lost_grant got=%h exp=%h", obs, {1'b1, 1'b1, 5'd4, 8'h00, 8'h00, 1'b0});
    end
    tick(); i_reti = 1'b1; tick(); i_reti = 1'b0;
  endtask

  task automatic test_nesting();
    i_irq_src = 8'h40; tick(); i_irq_src = 8'h00; tick();
    n_tests++;
    if (obs !== {1'b1, 1'b1, 5'd6, 8'h00, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL nest_outer got=%h exp=%h", obs, {1'b1, 1'b1, 5'd6, 8'h00, 8'h00, 1'b0});
    end
    tick();
    i_irq_src = 8'h01; tick(); i_irq_src = 8'h00;
    tick();
`ifdef VIC_NESTING_EN
    n_tests++;
    if (obs !== {1'b1, 1'b1, 5'd0, 8'h00, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL nest_preempt got=%h exp=%h", obs, {1'b1, 1'b1, 5'd0, 8'h00, 8'h00, 1'b0});
    end
    tick(); i_reti = 1'b1; tick(); i_reti = 1'b0;
    n_tests++;
    if (obs !== {1'b0, 1'b1, 5'd6, 8'h00, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL nest_pop got=%h exp=%h", obs, {1'b0, 1'b1, 5'd6, 8'h00, 8'h00, 1'b0});
    end
    tick(); i_reti = 1'b1; tick(); i_reti = 1'b0;
    n_tests++;
    if (obs !== {1'b0, 1'b0, 5'd6, 8'h00, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL nest_idle got=%h exp=%h", obs, {1'b0, 1'b0, 5'd6, 8'h00, 8'h00, 1'b0});
    end
`else
    n_tests++;
    if (obs !== {1'b0, 1'b1, 5'd6, 8'h01, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL nest_off_hold got=%h exp=%h", obs, {1'b0, 1'b1, 5'd6, 8'h01, 8'h00, 1'b0});
    end
    i_reti = 1'b1; tick(); i_reti = 1'b0;
    n_tests++;
    if (obs !== {1'b0, 1'b0, 5'd6, 8'h01, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL nest_off_idle got=%h exp=%h", obs, {1'b0, 1'b0, 5'd6, 8'h01, 8'h00, 1'b0});
    end
    tick();
    n_tests++;
    if (obs !== {1'b1, 1'b1, 5'd0, 8'h00, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL nest_off_grant got=%h exp=%h", obs, {1'b1, 1'b1, 5'd0, 8'h00, 8'h00, 1'b0});
    end
    tick(); i_reti = 1'b1; tick(); i_reti = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    i_irq_src = 8'h40; tick(); i_irq_src = 8'h00; tick(); tick();
    i_irq_src = 8'h30; tick(); i_irq_src = 8'h00;
    n_tests++;
    if (obs !== {1'b0, 1'b1, 5'd6, 8'h30, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL mid_before got=%h exp=%h", obs, {1'b0, 1'b1, 5'd6, 8'h30, 8'h00, 1'b0});
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (obs !== {1'b0, 1'b0, 5'd0, 8'h00, 8'hFF, 1'b0}) begin
      n_fail++; $display("FAIL mid_async got=%h exp=%h", obs, {1'b0, 1'b0, 5'd0, 8'h00, 8'hFF, 1'b0});
    end
    tick(); tick(); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_tests++;
      if (o_IRQ !== 1'b0 || o_busy !== 1'b0 || o_pending !== 8'h00) begin
        n_fail++; $display("FAIL mid_after irq=%b busy=%b pend=%h exp=0/0/00", o_IRQ, o_busy, o_pending);
      end
    end
  endtask

  task automatic test_random();
    logic prev_irq;
    rst = 1'b1; tick(); rst = 1'b0;
    prev_irq = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      i_irq_src  = i_irq_src ^ (N'($urandom) & N'($urandom) & N'($urandom));
      i_mask_we  = ($urandom_range(0, 15) == 0);
      i_mask_wdata = N'($urandom) & N'($urandom);
      i_lost_clr = ($urandom_range(0, 7) == 0);
      i_reti     = (m_mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      tick();
      n_tests++;
      if (obs !== mdl) begin
        n_fail++; $display("FAIL random_cycle%0d got=%h exp=%h", c, obs, mdl);
      end
      n_tests++;
      if (prev_irq && o_IRQ) begin
        n_fail++; $display("FAIL irq_consecutive cycle%0d got=1 exp=0", c);
      end
      prev_irq = o_IRQ;
    end
    i_irq_src = '0; i_mask_we = 1'b0; i_lost_clr = 1'b0; i_reti = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask_unmask();
    test_back_to_back();
    test_lost();
    test_nesting();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
